// File: rtl/risc_v_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_ctrl_pkg
//   Shared definitions for the multi-cycle RV32I controller:
//   - state_t : main FSM state encoding (also exported on the debug State port)
//   - opcode constants for the supported instruction classes
//   - ALUOp / ALUControl codes and the ResultSrc, ALUSrcA, ALUSrcB, ImmSrc
//     mux encodings
//   - imm_src() : opcode -> immediate format decode
// -----------------------------------------------------------------------------
package risc_v_ctrl_pkg;

  // Main FSM states. Encodings 11..15 are unused and fall back to FETCH.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp: selects how the ALU decoder forms ALUControl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format for an opcode. R-type and unknown opcodes carry no
  // immediate; I-format is returned so the extender output is still defined.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BR:   sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Combinational map from ALUOp (set by the main FSM) and the instruction's
//   funct3 / op[5] / funct7[5] fields to the ALUControl code.
// Ports
//   alu_op      in  2              00 add, 01 sub, 10 decode from funct3
//   funct3      in  FUNCT3_WIDTH   Instr[14:12]
//   op5         in  1              Instr[5]: 1 for R-type, 0 for I-type ALU
//   funct7_5    in  1              Instr[30]
//   alu_control out ALU_CTRL_WIDTH ALU operation code
// -----------------------------------------------------------------------------
module alu_decoder
  import risc_v_ctrl_pkg::*;
#(
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  logic [1:0]                alu_op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      op5,
  input  logic                      funct7_5,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] only selects sub for register-register ops; addi has
          // arbitrary immediate bits in that position.
          3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style main FSM plus ALU decoder for a multi-cycle RV32I datapath
//   (lw, sw, R-type, I-type ALU, beq/bne, jal) built around one shared ALU and
//   one unified instruction/data memory with a MemReady handshake.
// Ports
//   CLK        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   op         in   7  Instr[6:0] from the instruction register
//   funct3     in   3  Instr[14:12]
//   funct7_5   in   1  Instr[30]
//   Zero       in   1  ALU zero flag
//   MemReady   in   1  memory completes the current access this cycle
//   PCWrite    out  1  PC load enable
//   AdrSrc     out  1  memory address: 0=PC, 1=ALUOut
//   MemWrite   out  1  memory write enable
//   IRWrite    out  1  IR / OldPC load enable
//   ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 RD1
//   ALUSrcB    out  2  00 RD2, 01 ImmExt, 10 const 4
//   ImmSrc     out  2  00 I, 01 S, 10 B, 11 J (from op, every state)
//   ALUControl out  3  ALU operation
//   RegWrite   out  1  register file write enable
//   Retire     out  1  pulse in the last cycle of each instruction
//   Illegal    out  1  pulse when DECODE sees an unsupported opcode
//   State      out  4  current state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import risc_v_ctrl_pkg::*;
#(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int IMM_SRC_WIDTH  = 2,
  parameter int STATE_WIDTH    = 4
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic                      Zero,
  input  logic                      MemReady,
  output logic                      PCWrite,
  output logic                      AdrSrc,
  output logic                      MemWrite,
  output logic                      IRWrite,
  output logic [1:0]                ResultSrc,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic                      RegWrite,
  output logic                      Retire,
  output logic                      Illegal,
  output logic [STATE_WIDTH-1:0]    State
);

  state_t     state;
  logic [1:0] alu_op;

  // ---------------------------------------------------------------------------
  // Main FSM state register and transitions. MemReady is only looked at in
  // the three states that wait on memory.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (MemReady) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_BR:        state <= BRANCH;
            OP_JAL:       state <= JAL;
            default:      state <= FETCH;
          endcase
        end
        // op[5] is the only bit separating sw from lw.
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (MemReady) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (MemReady) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        // jal reuses ALUWB to write OldPC+4 to rd.
        JAL:      state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs follow the state, except for the handshake-gated
  // enables in FETCH/MEMWRITE, the branch condition and the illegal flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
    RegWrite  = 1'b0;
    Retire    = 1'b0;
    Illegal   = 1'b0;

    case (state)
      FETCH: begin
        // PC+4 goes straight from ALUResult into the PC while the memory
        // returns the instruction.
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        // Precompute OldPC+imm so BRANCH/JAL find their target in ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL: Illegal = 1'b0;
          default:                                 Illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      MEMWRITE: begin
        // MemWrite stays high through every wait cycle.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = MemReady;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      BRANCH: begin
        // Target is already in ALUOut; funct3[0] turns beq into bne.
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = Zero ^ funct3[0];
        Retire    = 1'b1;
      end
      JAL: begin
        // Load the jump target from ALUOut while the ALU forms OldPC+4.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase

    // Reset drops every architectural write and pulse immediately, so an
    // instruction caught mid-flight leaves no partial update behind.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Retire   = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign ImmSrc = imm_src(op);
  assign State  = state;

  alu_decoder #(
    .FUNCT3_WIDTH   (FUNCT3_WIDTH),
    .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Each instruction is expanded into the list of cycles it must take
//   (including memory wait cycles chosen up front) with the expected control
//   word for every cycle. A driver replays that list; a compare process
//   checks the DUT against the current expected word on each falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import risc_v_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7_5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_ctrl dut (
    .CLK        (CLK),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .Retire     (Retire),
    .Illegal    (Illegal),
    .State      (State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       mr;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] aluc;
    logic       regw;
    logic       ret;
    logic       ill;
    logic [3:0] st;
  } exp_t;

  // Cycle kinds of the expected trace
  localparam int ST_FW  = 0;   // fetch, memory not ready
  localparam int ST_FG  = 1;   // fetch, memory ready
  localparam int ST_DEC = 2;
  localparam int ST_ILL = 3;   // decode of an unsupported opcode
  localparam int ST_MA  = 4;
  localparam int ST_MRW = 5;
  localparam int ST_MRG = 6;
  localparam int ST_MWB = 7;
  localparam int ST_MWW = 8;
  localparam int ST_MWG = 9;
  localparam int ST_XR  = 10;
  localparam int ST_XI  = 11;
  localparam int ST_AWB = 12;
  localparam int ST_BR  = 13;
  localparam int ST_JAL = 14;
  localparam int ST_RST = 15;  // reset held

  int   total = 0;
  int   bad = 0;
  exp_t exp_cur;
  logic exp_valid = 1'b0;

  // Running totals kept only by the compare process
  int         obs_cyc = 0, obs_pcw = 0, obs_memw = 0, obs_regw = 0;
  int         obs_ret = 0, obs_ret_cyc = 0, obs_ill = 0, obs_irw = 0;
  logic [2:0] obs_exec_aluc = 3'b000;

  // Per-instruction deltas computed by the driver
  int d_cyc, d_pcw, d_memw, d_regw, d_ret, d_retcyc, d_ill, d_irw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic legal_op(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t mk(input int step, input logic z, input logic [2:0] f3,
                              input logic [6:0] o, input logic f7);
    exp_t e;
    e = '0;
    e.mr = 1'($urandom_range(0, 1));
    e.st = FETCH;
    case (step)
      ST_FW:  begin e.mr = 1'b0; e.b = 2'b10; e.res = 2'b10; end
      ST_FG:  begin e.mr = 1'b1; e.b = 2'b10; e.res = 2'b10; e.irw = 1'b1; e.pcw = 1'b1; end
      ST_DEC: begin e.a = 2'b01; e.b = 2'b01; e.st = DECODE; end
      ST_ILL: begin e.a = 2'b01; e.b = 2'b01; e.ill = 1'b1; e.st = DECODE; end
      ST_MA:  begin e.a = 2'b10; e.b = 2'b01; e.st = MEMADR; end
      ST_MRW: begin e.mr = 1'b0; e.adr = 1'b1; e.st = MEMREAD; end
      ST_MRG: begin e.mr = 1'b1; e.adr = 1'b1; e.st = MEMREAD; end
      ST_MWB: begin e.res = 2'b01; e.regw = 1'b1; e.ret = 1'b1; e.st = MEMWB; end
      ST_MWW: begin e.mr = 1'b0; e.adr = 1'b1; e.memw = 1'b1; e.st = MEMWRITE; end
      ST_MWG: begin e.mr = 1'b1; e.adr = 1'b1; e.memw = 1'b1; e.ret = 1'b1; e.st = MEMWRITE; end
      ST_XR:  begin e.a = 2'b10; e.b = 2'b00; e.aluc = funct_alu(f3, o[5], f7); e.st = EXECR; end
      ST_XI:  begin e.a = 2'b10; e.b = 2'b01; e.aluc = funct_alu(f3, o[5], f7); e.st = EXECI; end
      ST_AWB: begin e.res = 2'b00; e.regw = 1'b1; e.ret = 1'b1; e.st = ALUWB; end
      ST_BR:  begin
        e.a = 2'b10; e.b = 2'b00; e.aluc = 3'b001; e.ret = 1'b1;
        e.pcw = z ^ f3[0]; e.st = BRANCH;
      end
      ST_JAL: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; e.st = JAL; end
      default: begin e.b = 2'b10; e.res = 2'b10; end  // ST_RST: FETCH values, no enables
    endcase
    return e;
  endfunction

  // Compare process
  always @(negedge CLK) begin
    if (exp_valid) begin
      obs_cyc++;
      if (PCWrite)  obs_pcw++;
      if (MemWrite) obs_memw++;
      if (RegWrite) obs_regw++;
      if (IRWrite)  obs_irw++;
      if (Illegal)  obs_ill++;
      if (Retire) begin obs_ret++; obs_ret_cyc = obs_cyc; end
      if (exp_cur.st == EXECR || exp_cur.st == EXECI) obs_exec_aluc = ALUControl;
      chk("PCWrite",    PCWrite,    exp_cur.pcw);
      chk("AdrSrc",     AdrSrc,     exp_cur.adr);
      chk("MemWrite",   MemWrite,   exp_cur.memw);
      chk("IRWrite",    IRWrite,    exp_cur.irw);
      chk("ResultSrc",  ResultSrc,  exp_cur.res);
      chk("ALUSrcA",    ALUSrcA,    exp_cur.a);
      chk("ALUSrcB",    ALUSrcB,    exp_cur.b);
      chk("ALUControl", ALUControl, exp_cur.aluc);
      chk("RegWrite",   RegWrite,   exp_cur.regw);
      chk("Retire",     Retire,     exp_cur.ret);
      chk("Illegal",    Illegal,    exp_cur.ill);
      chk("State",      State,      exp_cur.st);
      chk("ImmSrc",     ImmSrc,     imm_of(op));
      chk("wr_excl",    RegWrite & MemWrite, 1'b0);
    end
  end

  // Runs one instruction; abort_at >= 0 raises rst on that cycle instead.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm, input int abort_at);
    exp_t q[$];
    int b_cyc, b_pcw, b_memw, b_regw, b_ret, b_ill, b_irw;
    for (int i = 0; i < wf; i++) q.push_back(mk(ST_FW, z, f3, o, f7));
    q.push_back(mk(ST_FG, z, f3, o, f7));
    q.push_back(mk(legal_op(o) ? ST_DEC : ST_ILL, z, f3, o, f7));
    if (o == 7'b0000011) begin
      q.push_back(mk(ST_MA, z, f3, o, f7));
      for (int i = 0; i < wm; i++) q.push_back(mk(ST_MRW, z, f3, o, f7));
      q.push_back(mk(ST_MRG, z, f3, o, f7));
      q.push_back(mk(ST_MWB, z, f3, o, f7));
    end else if (o == 7'b0100011) begin
      q.push_back(mk(ST_MA, z, f3, o, f7));
      for (int i = 0; i < wm; i++) q.push_back(mk(ST_MWW, z, f3, o, f7));
      q.push_back(mk(ST_MWG, z, f3, o, f7));
    end else if (o == 7'b0110011) begin
      q.push_back(mk(ST_XR, z, f3, o, f7));
      q.push_back(mk(ST_AWB, z, f3, o, f7));
    end else if (o == 7'b0010011) begin
      q.push_back(mk(ST_XI, z, f3, o, f7));
      q.push_back(mk(ST_AWB, z, f3, o, f7));
    end else if (o == 7'b1100011) begin
      q.push_back(mk(ST_BR, z, f3, o, f7));
    end else if (o == 7'b1101111) begin
      q.push_back(mk(ST_JAL, z, f3, o, f7));
      q.push_back(mk(ST_AWB, z, f3, o, f7));
    end

    b_cyc = obs_cyc; b_pcw = obs_pcw; b_memw = obs_memw; b_regw = obs_regw;
    b_ret = obs_ret; b_ill = obs_ill; b_irw = obs_irw;

    for (int i = 0; i < q.size(); i++) begin
      @(posedge CLK);
      #1;
      op = o; funct3 = f3; funct7_5 = f7; Zero = z; MemReady = q[i].mr;
      if (i == abort_at) begin
        rst = 1'b1;
        exp_cur = mk(ST_RST, z, f3, o, f7);
        exp_valid = 1'b1;
        break;
      end
      rst = 1'b0;
      exp_cur = q[i];
      exp_valid = 1'b1;
    end
    @(negedge CLK);
    #1;
    d_cyc = obs_cyc - b_cyc; d_pcw = obs_pcw - b_pcw; d_memw = obs_memw - b_memw;
    d_regw = obs_regw - b_regw; d_ret = obs_ret - b_ret; d_ill = obs_ill - b_ill;
    d_irw = obs_irw - b_irw; d_retcyc = obs_ret_cyc - b_cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ro;
    int         kind;

    // Reset state
    exp_cur = mk(ST_RST, 1'b0, 3'b000, op, 1'b0);
    exp_valid = 1'b1;
    @(negedge CLK); #1;
    MemReady = 1'b1;
    @(negedge CLK); #1;

    // lw, no wait states
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, -1);
    chk("lw_cycles", d_cyc, 5);
    chk("lw_regw", d_regw, 1);
    chk("lw_irw", d_irw, 1);
    chk("lw_retire_cycle", d_retcyc, 5);

    // sw with three memory wait cycles
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, -1);
    chk("sw_memw_cycles", d_memw, 4);
    chk("sw_retire", d_ret, 1);
    chk("sw_regw", d_regw, 0);
    chk("sw_cycles", d_cyc, 7);

    // sub and addi with funct7_5 set
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, -1);
    chk("sub_aluc", obs_exec_aluc, 3'b001);
    chk("sub_regw", d_regw, 1);
    chk("sub_cycles", d_cyc, 4);
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, -1);
    chk("addi_aluc", obs_exec_aluc, 3'b000);

    // beq / bne: PC written in FETCH plus when taken in BRANCH
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, -1);
    chk("beq_z1_pcw", d_pcw, 2);
    chk("beq_cycles", d_cyc, 3);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    chk("beq_z0_pcw", d_pcw, 1);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, -1);
    chk("bne_z1_pcw", d_pcw, 1);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, -1);
    chk("bne_z0_pcw", d_pcw, 2);

    // jal
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    chk("jal_pcw", d_pcw, 2);
    chk("jal_cycles", d_cyc, 4);
    chk("jal_regw", d_regw, 1);

    // illegal opcode
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    chk("ill_pulse", d_ill, 1);
    chk("ill_cycles", d_cyc, 2);

    // reset during MEMWB, then fetch resumes
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 4);
    chk("rst_regw", d_regw, 0);
    chk("rst_retire", d_ret, 0);
    @(posedge CLK); #1;
    @(negedge CLK); #1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 1, -1);
    chk("post_rst_lw_cycles", d_cyc, 7);
    chk("post_rst_lw_regw", d_regw, 1);

    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: ro = 7'b0000011;
        1: ro = 7'b0100011;
        2: ro = 7'b0110011;
        3: ro = 7'b0010011;
        4: ro = 7'b1100011;
        5: ro = 7'b1101111;
        default: begin
          ro = 7'($urandom);
          while (legal_op(ro)) ro = 7'($urandom);
        end
      endcase
      run_instr(ro, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
